// File: rtl/stack_height_arbiter.sv
// Owns the player's carried-box count and its derived height. Pickup, drop and hit requests
// are queued in saturating counters and serviced one per two game ticks (hit > drop > pickup).
module stack_height_arbiter #(
    parameter logic [9:0] PLAYER_BASE_HEIGHT = 10'd30,
    parameter logic [9:0] SEG_HEIGHT         = 10'd10,
    parameter logic [3:0] MAX_BOXES          = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic       pickup_req,
    input  logic       drop_req,
    input  logic       hit_req,
    output logic [3:0] box_count,
    output logic [9:0] player_current_height,
    output logic [2:0] grant,
    output logic       reject,
    output logic       stack_full,
    output logic       req_overflow
);

    typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

    state_t      state_reg;
    logic [1:0]  win_reg;
    logic [2:0]  grant_reg;
    logic        reject_reg;
    logic [3:0]  box_count_reg;
    logic [3:0]  box_count_next;
    logic [9:0]  height_reg;
    logic        full_reg;
    logic        overflow_reg;

    // Source index: 0 = pickup, 1 = drop, 2 = hit (matches the grant bit order).
    logic [2:0]  req;
    logic [2:0]  dec;
    logic [2:0]  lost;
    logic [1:0]  pend_reg [3];
    logic        any_pending;
    logic [1:0]  sel;
    logic        accept;

    assign req = {hit_req, drop_req, pickup_req};

    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
        assign dec[gi]  = (state_reg == APPLY) && (win_reg == 2'(gi));
        assign lost[gi] = req[gi] && !dec[gi] && (pend_reg[gi] == 2'd3);

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_reg[gi] <= 2'd0;
            end else if (req[gi] && !dec[gi]) begin
                if (pend_reg[gi] != 2'd3)
                    pend_reg[gi] <= pend_reg[gi] + 2'd1;
            end else if (!req[gi] && dec[gi]) begin
                pend_reg[gi] <= pend_reg[gi] - 2'd1;
            end
        end
    end

    always_comb begin
        any_pending = (pend_reg[0] != 2'd0) || (pend_reg[1] != 2'd0) || (pend_reg[2] != 2'd0);
        sel = 2'd0;
        if (pend_reg[2] != 2'd0)
            sel = 2'd2;
        else if (pend_reg[1] != 2'd0)
            sel = 2'd1;
        accept = (sel == 2'd0) ? (box_count_reg < MAX_BOXES) : (box_count_reg != 4'd0);
    end

    always_comb begin
        box_count_next = box_count_reg;
        if (state_reg == APPLY) begin
            if (grant_reg[0])
                box_count_next = box_count_reg + 4'd1;
            else if (grant_reg[1] || grant_reg[2])
                box_count_next = box_count_reg - 4'd1;
        end
    end

    // The verdict is decided on entry to APPLY so grant/reject are registered and live for APPLY only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            win_reg    <= 2'd0;
            grant_reg  <= 3'd0;
            reject_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    grant_reg  <= 3'd0;
                    reject_reg <= 1'b0;
                    if (game_en && any_pending) begin
                        win_reg   <= sel;
                        state_reg <= APPLY;
                        if (accept)
                            grant_reg <= 3'(3'b001 << sel);
                        else
                            reject_reg <= 1'b1;
                    end
                end
                APPLY: begin
                    grant_reg  <= 3'd0;
                    reject_reg <= 1'b0;
                    state_reg  <= HOLD;
                end
                HOLD: begin
                    if (game_en)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            box_count_reg <= 4'd0;
            height_reg    <= PLAYER_BASE_HEIGHT;
            full_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            box_count_reg <= box_count_next;
            height_reg    <= PLAYER_BASE_HEIGHT + SEG_HEIGHT * {6'd0, box_count_next};
            full_reg      <= (box_count_next == MAX_BOXES);
            if (lost != 3'd0)
                overflow_reg <= 1'b1;
        end
    end

    // A reset landing in APPLY discards the in-flight event, so its pulse is suppressed immediately.
    assign grant                 = grant_reg & {3{~rst}};
    assign reject                = reject_reg & ~rst;
    assign box_count             = box_count_reg;
    assign player_current_height = height_reg;
    assign stack_full            = full_reg;
    assign req_overflow          = overflow_reg;

endmodule

// File: tb/tb_stack_height_arbiter.sv
// Scoreboard bench for stack_height_arbiter: expected grant/reject events are queued when
// requests are driven and compared in order as the DUT emits them.
module tb_stack_height_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_en;
    logic       pickup_req;
    logic       drop_req;
    logic       hit_req;
    logic [3:0] box_count;
    logic [9:0] player_current_height;
    logic [2:0] grant;
    logic       reject;
    logic       stack_full;
    logic       req_overflow;

    int err_cnt   = 0;
    int check_cnt = 0;

    // Event code: {reject, grant[2:0]}
    logic [3:0] exp_q [$];

    localparam logic [3:0] EV_PICK = 4'b0001;
    localparam logic [3:0] EV_DROP = 4'b0010;
    localparam logic [3:0] EV_HIT  = 4'b0100;
    localparam logic [3:0] EV_REJ  = 4'b1000;

    stack_height_arbiter dut (
        .clk                   (clk),
        .rst                   (rst),
        .game_en               (game_en),
        .pickup_req            (pickup_req),
        .drop_req              (drop_req),
        .hit_req               (hit_req),
        .box_count             (box_count),
        .player_current_height (player_current_height),
        .grant                 (grant),
        .reject                (reject),
        .stack_full            (stack_full),
        .req_overflow          (req_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Every grant/reject pulse is one transaction, matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && (grant != 3'd0 || reject)) begin
            if (exp_q.size() == 0)
                check("unexpected_event", int'({reject, grant}), 0);
            else
                check("event", int'({reject, grant}), int'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] r);
        {hit_req, drop_req, pickup_req} = r;
        step();
        {hit_req, drop_req, pickup_req} = 3'b000;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            game_en = 1'b1;
            step();
            game_en = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic check_drained(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; game_en = 1'b0;
        pickup_req = 1'b0; drop_req = 1'b0; hit_req = 1'b0;
        do_reset();
        check("rst_box_count", box_count, 0);
        check("rst_height", player_current_height, 30);
        check("rst_grant_reject", {reject, grant}, 0);
        check("rst_full", stack_full, 0);
        check("rst_overflow", req_overflow, 0);

        // Three spaced pickups
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(EV_PICK);
            pulse_req(3'b001);
            ticks(2);
        end
        check_drained("pickups_drained");
        check("pickups_box_count", box_count, 3);
        check("pickups_height", player_current_height, 60);

        // Bring count to 2, then all three sources at once
        exp_q.push_back(EV_HIT);
        pulse_req(3'b100);
        ticks(2);
        check("pre_prio_box_count", box_count, 2);
        exp_q.push_back(EV_HIT);
        exp_q.push_back(EV_DROP);
        exp_q.push_back(EV_PICK);
        pulse_req(3'b111);
        ticks(6);
        check_drained("prio_drained");
        check("prio_box_count", box_count, 1);
        check("prio_height", player_current_height, 40);

        // Fill to capacity, then one more pickup is refused
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(EV_PICK);
            pulse_req(3'b001);
            ticks(2);
        end
        check("full_box_count", box_count, 8);
        check("full_height", player_current_height, 110);
        check("full_flag", stack_full, 1);
        exp_q.push_back(EV_REJ);
        pulse_req(3'b001);
        ticks(2);
        check_drained("full_drained");
        check("full_after_reject", box_count, 8);

        // Drop on an empty stack is refused, and nothing stays pending
        do_reset();
        exp_q.push_back(EV_REJ);
        pulse_req(3'b010);
        ticks(2);
        check("empty_drop_height", player_current_height, 30);
        ticks(4);
        check_drained("empty_drop_drained");
        check("empty_drop_full", stack_full, 0);

        // Five back-to-back pickups: the fourth overflows, three are serviced
        for (int i = 0; i < 5; i++) begin
            pulse_req(3'b001);
            if (i == 2) check("ovf_after_3", req_overflow, 0);
            if (i == 3) check("ovf_after_4", req_overflow, 1);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(EV_PICK);
        ticks(8);
        check_drained("ovf_drained");
        check("ovf_box_count", box_count, 3);
        check("ovf_sticky", req_overflow, 1);

        // Reset landing during APPLY discards the pickup
        do_reset();
        check("ovf_cleared", req_overflow, 0);
        pulse_req(3'b001);
        game_en = 1'b1;
        step();
        game_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_apply_grant", {reject, grant}, 0);
        step();
        rst = 1'b0;
        check("rst_apply_box_count", box_count, 0);
        check("rst_apply_height", player_current_height, 30);
        ticks(4);
        check("rst_apply_idle_count", box_count, 0);
        exp_q.push_back(EV_PICK);
        pulse_req(3'b001);
        ticks(2);
        check_drained("post_rst_drained");
        check("post_rst_box_count", box_count, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/stack_height_arbiter.md
Name: stack_height_arbiter

Overview:
- Owns the player's carried-box count and derives `player_current_height` from it; this is the single writer of the player height that the bank, collision and render logic read.
- Arbitrates three event sources that modify the stack: box pickup (collision), box drop (bank pulse) and hazard hit (lose a box).
- Requests may arrive on any `clk` cycle. They are queued in small saturating pending counters and serviced at most one per two `game_en` ticks, in a fixed priority order.

Parameters:
- PLAYER_BASE_HEIGHT, 10'd30, height in pixels with zero boxes carried.
- SEG_HEIGHT, 10'd10, pixels added per carried box.
- MAX_BOXES, 4'd8, stack capacity. PLAYER_BASE_HEIGHT + SEG_HEIGHT*MAX_BOXES must be ≤ 1023.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  synchronous reset, active high.
- game_en  input  1  slow game tick enable, one `clk` cycle wide.
- pickup_req  input  1  single-cycle request: add one box.
- drop_req  input  1  single-cycle request: remove one box (from bank logic).
- hit_req  input  1  single-cycle request: hazard removes one box.
- box_count  output  4  boxes currently carried.
- player_current_height  output  10  PLAYER_BASE_HEIGHT + SEG_HEIGHT*box_count.
- grant  output  3  one-hot {hit,drop,pickup}; single-cycle pulse in APPLY when the event is accepted.
- reject  output  1  single-cycle pulse in APPLY when the serviced event is refused.
- stack_full  output  1  high when box_count == MAX_BOXES.
- req_overflow  output  1  sticky error flag; set when a request is lost to saturation.

Behaviour:
- One clock domain; everything updates on `posedge clk`.
- `rst` has priority over all other logic and acts on the same edge it is sampled.
- Reset values:
  - box_count = 0
  - player_current_height = PLAYER_BASE_HEIGHT
  - grant = 0, reject = 0
  - stack_full = 0
  - req_overflow = 0
  - all pending counters = 0
  - state = IDLE
- Pending counters: pend_hit, pend_drop, pend_pick, 2 bits each, saturating at 3.
  - A request pulse increments its counter.
  - Servicing that source decrements it.
  - Increment and decrement on the same cycle leave the counter unchanged.
  - A request arriving while its counter is 3 (and no decrement that cycle) is dropped and sets req_overflow. req_overflow clears only on reset.
- State machine: IDLE, APPLY, HOLD.
  - IDLE: on a cycle with game_en = 1 and any pending counter nonzero, latch the winner and go to APPLY. Priority is hit > drop > pickup. Otherwise stay in IDLE.
  - APPLY (exactly one `clk` cycle): decrement the winner's pending counter, then apply the rule for the winner (listed below). Go to HOLD.
  - HOLD: stay until the next game_en = 1 cycle, then go to IDLE. That tick is not used for selection, so the service rate is at most one event per two game_en ticks.
- APPLY rule per winner:
  - Pickup: if box_count < MAX_BOXES, increment box_count and pulse grant[0]; else pulse reject.
  - Drop: if box_count > 0, decrement box_count and pulse grant[1]; else pulse reject.
  - Hit: if box_count > 0, decrement box_count and pulse grant[2]; else pulse reject.
- Output timing:
  - box_count, player_current_height and stack_full are registered and reflect the new count on the cycle after APPLY.
  - grant and reject are asserted during APPLY only; they are 0 in every other state.
- Arithmetic: player_current_height is computed at 10-bit width and cannot overflow given the parameter constraint. box_count never wraps past 0 or MAX_BOXES.
- A reset in APPLY or HOLD returns to IDLE with all state cleared; the in-flight event is discarded with no grant pulse.

Test Plan:
- Reset, then 3 pickup_req pulses spaced ≥ 2 ticks apart → grant = 001 three times; box_count = 3; player_current_height = 60.
- box_count = 2; hit_req, drop_req and pickup_req pulsed on the same `clk` cycle → grants in the order hit (100), drop (010), pickup (001) on successive service slots, ≥ 2 game_en ticks apart; final box_count = 1.
- Fill to MAX_BOXES = 8 (height 110, stack_full = 1), then pickup_req → reject pulses once; box_count stays 8.
- box_count = 0; drop_req → reject pulses; height stays 30; pend_drop returns to 0.
- 5 pickup_req pulses within one game tick from box_count = 0 → req_overflow = 1 after the 4th pulse; exactly 3 grants follow; box_count = 3.
- Assert rst during APPLY of a pickup → no grant pulse; box_count = 0 and height = 30 on the next cycle; state = IDLE.
